// File: rtl/risc_control_unit.sv
// Decode-stage control unit for the 16-bit RISC pipeline; registered outputs form the decode/execute register.
// Optional feature: define CU_INTERRUPT_EN to decode SYS (opcode 0x7) into IEN/IOF/RTI strobes.
module risc_control_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] IR,
    output logic [2:0]  reg_read_adr1_d,
    output logic [2:0]  reg_read_adr2_d,
    output logic [2:0]  reg_write_adr_d,
    output logic        reg_write_d,
    output logic        ALU_source2_d,
    output logic [7:0]  ALU_con_d,
    output logic [15:0] offset_register_d,
    output logic        mem_write_d,
    output logic        mem_to_reg_d,
    output logic        branch_d,
    output logic [3:0]  branch_condition_d,
    output logic        IEN_d,
    output logic        IOF_d,
    output logic        RTI_d
);

    localparam int unsigned RegAw  = 3;
    localparam int unsigned DataW  = 16;
    localparam int unsigned AluW   = 8;
    localparam int unsigned CondW  = 4;

    localparam logic [3:0] OpNop  = 4'h0;
    localparam logic [3:0] OpAlu  = 4'h1;
    localparam logic [3:0] OpAddi = 4'h2;
    localparam logic [3:0] OpLdi  = 4'h3;
    localparam logic [3:0] OpLd   = 4'h4;
    localparam logic [3:0] OpSt   = 4'h5;
    localparam logic [3:0] OpBr   = 4'h6;
    localparam logic [3:0] OpSys  = 4'h7;

    localparam logic [AluW-1:0] AluAdd   = 8'h01;
    localparam logic [AluW-1:0] AluPassB = 8'h80;

    typedef struct packed {
        logic [RegAw-1:0] ra1;
        logic [RegAw-1:0] ra2;
        logic [RegAw-1:0] wa;
        logic             rw;
        logic             src2;
        logic [AluW-1:0]  alu;
        logic [DataW-1:0] off;
        logic             mw;
        logic             m2r;
        logic             br;
        logic [CondW-1:0] bc;
        logic             ien;
        logic             iof;
        logic             rti;
    } ctrl_t;

    ctrl_t ctrl_d;
    ctrl_t ctrl_q;

    logic [DataW-1:0] imm6_sext;
    logic [DataW-1:0] imm8_sext;
    logic [DataW-1:0] imm9_sext;

    assign imm6_sext = {{10{IR[5]}}, IR[5:0]};
    assign imm8_sext = {{8{IR[7]}},  IR[7:0]};
    assign imm9_sext = {{7{IR[8]}},  IR[8:0]};

    // Instruction decode; anything not assigned for an opcode stays zero.
    always_comb begin
        ctrl_d = '0;
        case (IR[15:12])
            OpAlu: begin
                ctrl_d.wa   = IR[11:9];
                ctrl_d.ra1  = IR[8:6];
                ctrl_d.ra2  = IR[5:3];
                ctrl_d.alu  = AluW'(8'h01 << IR[2:0]);
                ctrl_d.rw   = 1'b1;
            end
            OpAddi: begin
                ctrl_d.wa   = IR[11:9];
                ctrl_d.ra1  = IR[8:6];
                ctrl_d.off  = imm6_sext;
                ctrl_d.alu  = AluAdd;
                ctrl_d.src2 = 1'b1;
                ctrl_d.rw   = 1'b1;
            end
            OpLdi: begin
                ctrl_d.wa   = IR[11:9];
                ctrl_d.off  = imm9_sext;
                ctrl_d.alu  = AluPassB;
                ctrl_d.src2 = 1'b1;
                ctrl_d.rw   = 1'b1;
            end
            OpLd: begin
                ctrl_d.wa   = IR[11:9];
                ctrl_d.ra1  = IR[8:6];
                ctrl_d.off  = imm6_sext;
                ctrl_d.alu  = AluAdd;
                ctrl_d.src2 = 1'b1;
                ctrl_d.rw   = 1'b1;
                ctrl_d.m2r  = 1'b1;
            end
            OpSt: begin
                ctrl_d.ra2  = IR[11:9];
                ctrl_d.ra1  = IR[8:6];
                ctrl_d.off  = imm6_sext;
                ctrl_d.alu  = AluAdd;
                ctrl_d.src2 = 1'b1;
                ctrl_d.mw   = 1'b1;
            end
            OpBr: begin
                ctrl_d.br   = 1'b1;
                ctrl_d.bc   = IR[11:8];
                ctrl_d.off  = imm8_sext;
            end
`ifdef CU_INTERRUPT_EN
            OpSys: begin
                ctrl_d.ien  = (IR[1:0] == 2'b01);
                ctrl_d.iof  = (IR[1:0] == 2'b10);
                ctrl_d.rti  = (IR[1:0] == 2'b11);
            end
`else
            OpSys: ;
`endif
            OpNop: ;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_q <= '0;
        end else begin
            ctrl_q <= ctrl_d;
        end
    end

    assign reg_read_adr1_d    = ctrl_q.ra1;
    assign reg_read_adr2_d    = ctrl_q.ra2;
    assign reg_write_adr_d    = ctrl_q.wa;
    assign reg_write_d        = ctrl_q.rw;
    assign ALU_source2_d      = ctrl_q.src2;
    assign ALU_con_d          = ctrl_q.alu;
    assign offset_register_d  = ctrl_q.off;
    assign mem_write_d        = ctrl_q.mw;
    assign mem_to_reg_d       = ctrl_q.m2r;
    assign branch_d           = ctrl_q.br;
    assign branch_condition_d = ctrl_q.bc;
    assign IEN_d              = ctrl_q.ien;
    assign IOF_d              = ctrl_q.iof;
    assign RTI_d              = ctrl_q.rti;

endmodule

// File: tb/tb_risc_control_unit.sv
// Scoreboard bench for risc_control_unit: driver queues hand-computed decodes, monitor checks each clock.
module tb_risc_control_unit;

    typedef struct packed {
        logic [2:0]  ra1;
        logic [2:0]  ra2;
        logic [2:0]  wa;
        logic        rw;
        logic        src2;
        logic [7:0]  alu;
        logic [15:0] off;
        logic        mw;
        logic        m2r;
        logic        br;
        logic [3:0]  bc;
        logic        ien;
        logic        iof;
        logic        rti;
    } exp_t;

    typedef struct {
        string nm;
        exp_t  e;
    } sb_t;

    logic        clk;
    logic        rst;
    logic [15:0] IR;
    logic [2:0]  reg_read_adr1_d, reg_read_adr2_d, reg_write_adr_d;
    logic        reg_write_d, ALU_source2_d;
    logic [7:0]  ALU_con_d;
    logic [15:0] offset_register_d;
    logic        mem_write_d, mem_to_reg_d, branch_d;
    logic [3:0]  branch_condition_d;
    logic        IEN_d, IOF_d, RTI_d;

    sb_t sb_q[$];
    int  n_vec = 0;
    int  n_err = 0;

    risc_control_unit dut (
        .clk                (clk),
        .rst                (rst),
        .IR                 (IR),
        .reg_read_adr1_d    (reg_read_adr1_d),
        .reg_read_adr2_d    (reg_read_adr2_d),
        .reg_write_adr_d    (reg_write_adr_d),
        .reg_write_d        (reg_write_d),
        .ALU_source2_d      (ALU_source2_d),
        .ALU_con_d          (ALU_con_d),
        .offset_register_d  (offset_register_d),
        .mem_write_d        (mem_write_d),
        .mem_to_reg_d       (mem_to_reg_d),
        .branch_d           (branch_d),
        .branch_condition_d (branch_condition_d),
        .IEN_d              (IEN_d),
        .IOF_d              (IOF_d),
        .RTI_d              (RTI_d)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t actual();
        exp_t a;
        a.ra1 = reg_read_adr1_d;   a.ra2 = reg_read_adr2_d;  a.wa  = reg_write_adr_d;
        a.rw  = reg_write_d;       a.src2 = ALU_source2_d;   a.alu = ALU_con_d;
        a.off = offset_register_d; a.mw  = mem_write_d;      a.m2r = mem_to_reg_d;
        a.br  = branch_d;          a.bc  = branch_condition_d;
        a.ien = IEN_d;             a.iof = IOF_d;            a.rti = RTI_d;
        return a;
    endfunction

    function automatic exp_t mk(input logic [2:0] ra1, input logic [2:0] ra2, input logic [2:0] wa,
                                input logic rw, input logic src2, input logic [7:0] alu,
                                input logic [15:0] off, input logic mw, input logic m2r,
                                input logic br, input logic [3:0] bc, input logic [2:0] irq);
        exp_t e;
        e.ra1 = ra1; e.ra2 = ra2; e.wa = wa; e.rw = rw; e.src2 = src2; e.alu = alu;
        e.off = off; e.mw = mw; e.m2r = m2r; e.br = br; e.bc = bc;
        e.ien = irq[2]; e.iof = irq[1]; e.rti = irq[0];
        return e;
    endfunction

    task automatic check(input string nm, input exp_t got, input exp_t want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, got, want);
        end
    endtask

    // Drive one IR at the falling edge and queue its decode for the next rising edge.
    task automatic apply(input string nm, input logic [15:0] ir, input exp_t e);
        sb_t s;
        @(negedge clk);
        IR = ir;
        s.nm = nm;
        s.e  = e;
        sb_q.push_back(s);
    endtask

    // Monitor: the registered outputs are valid every cycle, so pop one entry per rising edge.
    always @(posedge clk) begin
        sb_t s;
        #1;
        if (sb_q.size() > 0) begin
            s = sb_q.pop_front();
            check(s.nm, actual(), s.e);
        end
    end

    exp_t z;
    exp_t sys_rti, sys_ien, sys_iof;

    initial begin
        z = '0;
`ifdef CU_INTERRUPT_EN
        sys_rti = mk(0,0,0,0,0,8'h00,16'h0000,0,0,0,4'h0,3'b001);
        sys_ien = mk(0,0,0,0,0,8'h00,16'h0000,0,0,0,4'h0,3'b100);
        sys_iof = mk(0,0,0,0,0,8'h00,16'h0000,0,0,0,4'h0,3'b010);
`else
        sys_rti = '0;
        sys_ien = '0;
        sys_iof = '0;
`endif
        rst = 1'b1;
        IR  = 16'h1000;
        apply("reset_hold", 16'h1000, z);
        apply("reset_hold2", 16'h1000, z);
        @(negedge clk);
        rst = 1'b0;
        sb_q.push_back('{nm: "rst_release_alu_add", e: mk(0,0,0,1,0,8'h01,16'h0000,0,0,0,4'h0,3'b000)});

        apply("addi_zero",    16'h2000, mk(0,0,0,1,1,8'h01,16'h0000,0,0,0,4'h0,3'b000));
        apply("alu_shr",      16'h1A5E, mk(1,3,5,1,0,8'h40,16'h0000,0,0,0,4'h0,3'b000));
        apply("alu_passb",    16'h1007, mk(0,0,0,1,0,8'h80,16'h0000,0,0,0,4'h0,3'b000));
        apply("alu_all7",     16'h1FF8, mk(7,7,7,1,0,8'h01,16'h0000,0,0,0,4'h0,3'b000));
        apply("addi_pos_max", 16'h2A9F, mk(2,0,5,1,1,8'h01,16'h001F,0,0,0,4'h0,3'b000));
        apply("addi_neg_min", 16'h2020, mk(0,0,0,1,1,8'h01,16'hFFE0,0,0,0,4'h0,3'b000));
        apply("ldi_neg",      16'h3BFF, mk(0,0,5,1,1,8'h80,16'hFFFF,0,0,0,4'h0,3'b000));
        apply("ldi_pos",      16'h3EFF, mk(0,0,7,1,1,8'h80,16'h00FF,0,0,0,4'h0,3'b000));
        apply("ld_neg1",      16'h4B7F, mk(5,0,5,1,1,8'h01,16'hFFFF,0,1,0,4'h0,3'b000));
        apply("st_r6",        16'h5C80, mk(2,6,0,0,1,8'h01,16'h0000,1,0,0,4'h0,3'b000));
        apply("br_neg",       16'h6180, mk(0,0,0,0,0,8'h00,16'hFF80,0,0,1,4'h1,3'b000));
        apply("br_pos",       16'h6F7F, mk(0,0,0,0,0,8'h00,16'h007F,0,0,1,4'hF,3'b000));
        apply("sys_rti",      16'h7003, sys_rti);
        apply("sys_ien",      16'h7001, sys_ien);
        apply("sys_iof",      16'h7FFE, sys_iof);
        apply("sys_nop",      16'h7000, z);
        apply("nop",          16'h0FFF, z);
        apply("rsvd_f",       16'hF123, z);
        apply("rsvd_8",       16'h8FFF, z);

        // Drain with a bounded wait.
        for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge clk);
        if (sb_q.size() > 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
        end

        // Asynchronous reset mid-cycle clears a live decode immediately.
        @(negedge clk);
        IR = 16'h4B7F;
        @(posedge clk);
        #1;
        check("pre_async_rst", actual(), mk(5,0,5,1,1,8'h01,16'hFFFF,0,1,0,4'h0,3'b000));
        #2;
        rst = 1'b1;
        #1;
        check("async_rst", actual(), z);
        @(posedge clk);
        #1;
        check("rst_held", actual(), z);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
